// File: rtl/conv33_window_pkg.sv
// Shared constants for the conv33 family: window geometry and index-width helper.
// Window index convention: r=0 is the oldest row (row-2), c=0 is the leftmost column (col-2).
package conv33_window_pkg;

    localparam int WIN_N          = 3;
    localparam int WIN_ROW_OLDEST = 0;
    localparam int WIN_COL_LEFT   = 0;

    // Counter/address width for a dimension of n entries; never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv33_linebuf.sv
// One image row of storage: synchronous write, asynchronous read-before-write.
// Small and addressed by column, so it maps onto distributed RAM.
module conv33_linebuf
    import conv33_window_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 28,
    localparam int AW        = idx_w(DEPTH)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Combinational read returns the pre-write contents within the write cycle.
    assign rd_data = mem[addr];

endmodule

// File: rtl/conv33_window.sv
// Streaming 3x3 sliding-window generator: two line buffers feed the right column of a
// 3x3 register window, emitted under a single-register valid/ready handshake.
module conv33_window
    import conv33_window_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid_in,
    output logic                  pix_ready_out,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  win_valid_out,
    input  logic                  win_ready_in,
    output logic [DATA_WIDTH-1:0] win_0_0,
    output logic [DATA_WIDTH-1:0] win_0_1,
    output logic [DATA_WIDTH-1:0] win_0_2,
    output logic [DATA_WIDTH-1:0] win_1_0,
    output logic [DATA_WIDTH-1:0] win_1_1,
    output logic [DATA_WIDTH-1:0] win_1_2,
    output logic [DATA_WIDTH-1:0] win_2_0,
    output logic [DATA_WIDTH-1:0] win_2_1,
    output logic [DATA_WIDTH-1:0] win_2_2,
    output logic                  win_last
);

    localparam int COL_W = idx_w(IMG_W);
    localparam int ROW_W = idx_w(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] win [WIN_N][WIN_N];
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic                  win_valid_q;
    logic                  win_last_q;
    logic                  acc;
    logic                  emit;
    logic                  at_col_last;
    logic                  at_row_last;

    assign pix_ready_out = ~win_valid_q | win_ready_in;
    assign acc           = pix_valid_in & pix_ready_out;
    assign at_col_last   = (col == COL_LAST);
    assign at_row_last   = (row == ROW_LAST);
    assign emit          = (row >= ROW_FIRST) && (col >= COL_FIRST);

    // lb0 holds the previous row, lb1 the row before it; lb1 is refilled from lb0's old word.
    conv33_linebuf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .addr    (col),
        .wr_en   (acc),
        .wr_data (pix_data),
        .rd_data (lb0_rd)
    );

    conv33_linebuf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .addr    (col),
        .wr_en   (acc),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (acc) begin
            for (int r = 0; r < WIN_N; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= pix_data;

            if (at_col_last) begin
                col <= '0;
                row <= at_row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end

            // Left-edge accepts still shift but never emit, so row-wrap stale columns stay hidden.
            win_valid_q <= emit;
            win_last_q  <= emit && at_row_last && at_col_last;
        end else if (win_ready_in) begin
            win_valid_q <= 1'b0;
        end
    end

    assign win_valid_out = win_valid_q;
    assign win_last      = win_last_q;
    assign win_0_0       = win[0][0];
    assign win_0_1       = win[0][1];
    assign win_0_2       = win[0][2];
    assign win_1_0       = win[1][0];
    assign win_1_1       = win[1][1];
    assign win_1_2       = win[1][2];
    assign win_2_0       = win[2][0];
    assign win_2_1       = win[2][1];
    assign win_2_2       = win[2][2];

endmodule

// File: tb/tb_conv33_window.sv
// Scoreboard bench for conv33_window: a 4x4 instance and a 5x3 instance.
module tb_conv33_window;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance (sel 0)
    logic       rst4 = 1'b0, pv4 = 1'b0, wr4 = 1'b1;
    logic       pr4, wv4, wl4;
    logic [7:0] pd4 = '0;
    logic [7:0] w4 [9];
    logic [72:0] got4;

    // 5x3 instance (sel 1)
    logic       rst5 = 1'b0, pv5 = 1'b0, wr5 = 1'b1;
    logic       pr5, wv5, wl5;
    logic [7:0] pd5 = '0;
    logic [7:0] w5 [9];
    logic [72:0] got5;

    conv33_window #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst(rst4), .pix_valid_in(pv4), .pix_ready_out(pr4), .pix_data(pd4),
        .win_valid_out(wv4), .win_ready_in(wr4),
        .win_0_0(w4[0]), .win_0_1(w4[1]), .win_0_2(w4[2]),
        .win_1_0(w4[3]), .win_1_1(w4[4]), .win_1_2(w4[5]),
        .win_2_0(w4[6]), .win_2_1(w4[7]), .win_2_2(w4[8]),
        .win_last(wl4)
    );

    conv33_window #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(3)) dut53 (
        .clk(clk), .rst(rst5), .pix_valid_in(pv5), .pix_ready_out(pr5), .pix_data(pd5),
        .win_valid_out(wv5), .win_ready_in(wr5),
        .win_0_0(w5[0]), .win_0_1(w5[1]), .win_0_2(w5[2]),
        .win_1_0(w5[3]), .win_1_1(w5[4]), .win_1_2(w5[5]),
        .win_2_0(w5[6]), .win_2_1(w5[7]), .win_2_2(w5[8]),
        .win_last(wl5)
    );

    assign got4 = {wl4, w4[0], w4[1], w4[2], w4[3], w4[4], w4[5], w4[6], w4[7], w4[8]};
    assign got5 = {wl5, w5[0], w5[1], w5[2], w5[3], w5[4], w5[5], w5[6], w5[7], w5[8]};

    localparam logic [72:0] FIRST4 = {1'b0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    localparam logic [72:0] LAST4  = {1'b1, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    localparam logic [72:0] F2_4   = {1'b0, 8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110};
    localparam logic [72:0] LAST53 = {1'b1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14};

    int checks = 0;
    int errors = 0;
    int nwin   = 0;
    int mr     = 0;
    int mc     = 0;
    logic [7:0]  fr [16];
    logic [72:0] exp_q[$];
    logic [72:0] got_hist[$];

    // One clock of stimulus: pop/compare a taken window, then push the expected window
    // for an accepted pixel. Expected windows come from the bench's own pixel image.
    task automatic step(input int sel, input logic v, input logic rdy, input logic [7:0] d,
                        output logic acc);
        logic [72:0] got, e;
        logic        wv, pr;
        int          w, h;
        @(negedge clk);
        if (sel == 0) begin pv4 = v; pd4 = d; wr4 = rdy; end
        else          begin pv5 = v; pd5 = d; wr5 = rdy; end
        #1;
        got = (sel == 0) ? got4 : got5;
        wv  = (sel == 0) ? wv4 : wv5;
        pr  = (sel == 0) ? pr4 : pr5;
        w   = (sel == 0) ? 4 : 5;
        h   = (sel == 0) ? 4 : 3;
        if (wv && rdy) begin
            checks++;
            nwin++;
            got_hist.push_back(got);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL window_unexpected got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL window_data got=%h required=%h", got, e);
                end
            end
        end
        acc = v && pr;
        if (acc) begin
            fr[mr*w + mc] = d;
            if (mr >= 2 && mc >= 2) begin
                e = 73'((mr == h-1) && (mc == w-1));
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e = (e << 8) | 73'(fr[(mr-2+i)*w + (mc-2+j)]);
                exp_q.push_back(e);
            end
            if (mc == w-1) begin
                mc = 0;
                mr = (mr == h-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic send_range(input int sel, input int first, input int n, input bit bubbles);
        int   sent = 0;
        int   guard = 0;
        logic v, a;
        while (sent < n && guard < 2000) begin
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            step(sel, v, 1'b1, 8'(first + sent), a);
            if (a) sent++;
            guard++;
        end
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL send_timeout sent=%0d required=%0d", sent, n);
        end
    endtask

    task automatic drain(input int sel);
        logic a;
        repeat (4) step(sel, 1'b0, 1'b1, 8'd0, a);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL windows_missing pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        if (sel == 0) begin rst4 = 1'b1; pv4 = 1'b0; wr4 = 1'b1; end
        else          begin rst5 = 1'b1; pv5 = 1'b0; wr5 = 1'b1; end
        @(negedge clk);
        checks++;
        if (((sel == 0) ? wv4 : wv5) !== 1'b0) begin
            errors++;
            $display("FAIL valid_during_reset got=%b required=0", (sel == 0) ? wv4 : wv5);
        end
        @(negedge clk);
        if (sel == 0) rst4 = 1'b0; else rst5 = 1'b0;
        mr = 0;
        mc = 0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (((sel == 0) ? wv4 : wv5) !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_reset got=%b required=0", (sel == 0) ? wv4 : wv5);
        end
    endtask

    task automatic start_test();
        nwin = 0;
        got_hist.delete();
    endtask

    task automatic check_count(input int required);
        checks++;
        if (nwin != required) begin
            errors++;
            $display("FAIL window_count got=%0d required=%0d", nwin, required);
        end
    endtask

    task automatic test_reset();
        do_reset(0);
        do_reset(1);
        checks++;
        if (got4 !== 73'd0) begin
            errors++;
            $display("FAIL reset_window4 got=%h required=0", got4);
        end
        checks++;
        if (got5 !== 73'd0) begin
            errors++;
            $display("FAIL reset_window53 got=%h required=0", got5);
        end
        checks++;
        if (pr4 !== 1'b1 || pr5 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b%b required=11", pr4, pr5);
        end
    endtask

    task automatic test_basic();
        start_test();
        send_range(0, 0, 16, 1'b0);
        drain(0);
        check_count(4);
        checks++;
        if (got_hist.size() < 1 || got_hist[0] !== FIRST4) begin
            errors++;
            $display("FAIL basic_first got=%h required=%h", got4, FIRST4);
        end
        checks++;
        if (got_hist.size() < 4 || got_hist[3] !== LAST4) begin
            errors++;
            $display("FAIL basic_last got=%h required=%h", got4, LAST4);
        end
    endtask

    task automatic test_backpressure();
        logic a;
        start_test();
        for (int i = 0; i < 11; i++) step(0, 1'b1, 1'b1, 8'(i), a);
        for (int k = 0; k < 5; k++) begin
            step(0, 1'b1, 1'b0, 8'd11, a);
            checks++;
            if (wv4 !== 1'b1 || got4 !== FIRST4) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d valid=%b got=%h required=%h", k, wv4, got4, FIRST4);
            end
            checks++;
            if (pr4 !== 1'b0 || a !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready cyc=%0d got=%b required=0", k, pr4);
            end
        end
        send_range(0, 11, 5, 1'b0);
        drain(0);
        check_count(4);
        checks++;
        if (got_hist.size() < 4 || got_hist[0] !== FIRST4 || got_hist[3] !== LAST4) begin
            errors++;
            $display("FAIL stall_sequence got=%h required=%h", got4, LAST4);
        end
    endtask

    task automatic test_bubbles();
        start_test();
        send_range(0, 0, 16, 1'b1);
        drain(0);
        check_count(4);
        checks++;
        if (got_hist.size() < 4 || got_hist[0] !== FIRST4 || got_hist[3] !== LAST4) begin
            errors++;
            $display("FAIL bubble_sequence got=%h required=%h", got4, LAST4);
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        send_range(0, 0, 16, 1'b0);
        send_range(0, 100, 16, 1'b0);
        drain(0);
        check_count(8);
        checks++;
        if (got_hist.size() < 5 || got_hist[4] !== F2_4) begin
            errors++;
            $display("FAIL frame2_first got=%h required=%h", got4, F2_4);
        end
    endtask

    task automatic test_reset_mid();
        start_test();
        send_range(0, 50, 7, 1'b0);
        do_reset(0);
        send_range(0, 0, 16, 1'b0);
        drain(0);
        check_count(4);
        checks++;
        if (got_hist.size() < 4 || got_hist[0] !== FIRST4 || got_hist[3] !== LAST4) begin
            errors++;
            $display("FAIL midreset_sequence got=%h required=%h", got4, LAST4);
        end
    endtask

    task automatic test_nonsquare();
        start_test();
        do_reset(1);
        send_range(1, 0, 15, 1'b0);
        drain(1);
        check_count(3);
        checks++;
        if (got_hist.size() < 3 || got_hist[2] !== LAST53) begin
            errors++;
            $display("FAIL nonsquare_last got=%h required=%h", got5, LAST53);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        test_nonsquare();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
